// File: rtl/fpnew_pkg.sv
// Shared FPU types plus the request bundle and tag packing used
// when several requesters share one FPU instance.
package fpnew_pkg;

  typedef enum logic [3:0] {
    FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
    CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
  } operation_e;

  typedef enum logic [2:0] {
    RNE = 3'b000, RTZ = 3'b001, RDN = 3'b010,
    RUP = 3'b011, RMM = 3'b100, DYN = 3'b111
  } roundmode_e;

  typedef enum logic [2:0] {
    FP32, FP64, FP16, FP8, FP16ALT
  } fp_format_e;

  typedef enum logic [1:0] {
    INT8, INT16, INT32, INT64
  } int_format_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } status_t;

  typedef struct packed {
    operation_e  op;
    logic        op_mod;
    roundmode_e  rnd_mode;
    fp_format_e  src_fmt;
    fp_format_e  dst_fmt;
    int_format_e int_fmt;
    logic        vectorial_op;
  } req_ctrl_t;

  localparam int unsigned ReqArbTagMaxW = 32;

  typedef logic [ReqArbTagMaxW-1:0] req_arb_tag_t;

  // {requester index, user tag}, truncated by the caller to IdxW+UserTagWidth
  function automatic req_arb_tag_t req_arb_tag(
    input int unsigned  num_req,
    input int unsigned  user_w,
    input int unsigned  idx,
    input req_arb_tag_t user
  );
    req_arb_tag_t idx_mask;
    req_arb_tag_t user_mask;
    idx_mask  = (req_arb_tag_t'(1) << $clog2(num_req)) - req_arb_tag_t'(1);
    user_mask = (req_arb_tag_t'(1) << user_w) - req_arb_tag_t'(1);
    return ((req_arb_tag_t'(idx) & idx_mask) << user_w) | (user & user_mask);
  endfunction

endpackage

// File: rtl/fpnew_rr_lock_arbiter.sv
// Round-robin arbiter that holds its grant while the sink stalls,
// keeping valid/data stable across back-pressure.
module fpnew_rr_lock_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [N-1:0]         elig,
  input  logic                 ready,
  output logic                 valid,
  output logic [$clog2(N)-1:0] idx,
  output logic [N-1:0]         gnt
);

  localparam int unsigned IdxW = $clog2(N);

  logic [IdxW-1:0] ptr_q;
  logic [IdxW-1:0] lock_idx_q;
  logic            lock_q;

  always_comb begin
    int unsigned jj;
    logic        found;
    jj    = 0;
    found = 1'b0;
    valid = |elig;
    idx   = '0;
    if (lock_q && elig[lock_idx_q]) begin
      idx = lock_idx_q;
    end else begin
      for (int k = 0; k < N; k++) begin
        jj = (32'(ptr_q) + 32'(k)) % N;
        if (!found && elig[jj[IdxW-1:0]]) begin
          found = 1'b1;
          idx   = jj[IdxW-1:0];
        end
      end
    end
    gnt = {N{valid}} & (N'(1) << idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (flush) begin
      lock_q <= 1'b0;
    end else begin
      lock_q <= valid & ~ready;
      if (valid && !ready) begin
        lock_idx_q <= idx;
      end
      if (valid && ready) begin
        ptr_q <= (32'(idx) == N - 1) ? '0 : idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpnew_req_arbiter.sv
// Shares one FPU among NumReq requesters: round-robin issue with stall
// lock, per-requester credits, and result routing via the FPU tag.
module fpnew_req_arbiter
  import fpnew_pkg::*;
#(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned Width          = 32,
  parameter int unsigned NumOperands    = 3,
  parameter int unsigned UserTagWidth   = 4,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned IdxW = $clog2(NumReq),
  localparam int unsigned TagW = IdxW + UserTagWidth
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic                                          flush_i,
  input  logic        [NumReq-1:0]                      req_valid_i,
  output logic        [NumReq-1:0]                      req_ready_o,
  input  logic        [NumReq-1:0][NumOperands-1:0][Width-1:0] req_operands_i,
  input  operation_e  [NumReq-1:0]                      req_op_i,
  input  logic        [NumReq-1:0]                      req_op_mod_i,
  input  roundmode_e  [NumReq-1:0]                      req_rnd_mode_i,
  input  fp_format_e  [NumReq-1:0]                      req_src_fmt_i,
  input  fp_format_e  [NumReq-1:0]                      req_dst_fmt_i,
  input  int_format_e [NumReq-1:0]                      req_int_fmt_i,
  input  logic        [NumReq-1:0]                      req_vectorial_op_i,
  input  logic        [NumReq-1:0][UserTagWidth-1:0]    req_tag_i,
  output logic                                          fpu_in_valid_o,
  input  logic                                          fpu_in_ready_i,
  output logic        [NumOperands-1:0][Width-1:0]      fpu_operands_o,
  output operation_e                                    fpu_op_o,
  output logic                                          fpu_op_mod_o,
  output roundmode_e                                    fpu_rnd_mode_o,
  output fp_format_e                                    fpu_src_fmt_o,
  output fp_format_e                                    fpu_dst_fmt_o,
  output int_format_e                                   fpu_int_fmt_o,
  output logic                                          fpu_vectorial_op_o,
  output logic        [TagW-1:0]                        fpu_tag_o,
  input  logic                                          fpu_out_valid_i,
  output logic                                          fpu_out_ready_o,
  input  logic        [Width-1:0]                       fpu_result_i,
  input  status_t                                       fpu_status_i,
  input  logic        [TagW-1:0]                        fpu_tag_i,
  output logic        [NumReq-1:0]                      rsp_valid_o,
  input  logic        [NumReq-1:0]                      rsp_ready_i,
  output logic        [Width-1:0]                       rsp_result_o,
  output status_t                                       rsp_status_o,
  output logic        [UserTagWidth-1:0]                rsp_tag_o,
  output logic                                          busy_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  typedef struct packed {
    logic [NumOperands-1:0][Width-1:0] operands;
    req_ctrl_t                         ctrl;
    logic [UserTagWidth-1:0]           tag;
  } req_t;

  req_t [NumReq-1:0]             lane;
  req_t                          sel;
  logic [NumReq-1:0]             elig;
  logic [NumReq-1:0]             gnt;
  logic [NumReq-1:0]             rsp_hs;
  logic [IdxW-1:0]               gnt_idx;
  logic [IdxW-1:0]               rsp_idx;
  logic                          arb_valid;
  logic                          idx_ok;
  logic [NumReq-1:0][CntW-1:0]   cnt_q;

  // Gating eligibility with rst_ni keeps every output at its reset
  // value for the whole reset window, not just after the next edge.
  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      lane[i].operands          = req_operands_i[i];
      lane[i].ctrl.op           = req_op_i[i];
      lane[i].ctrl.op_mod       = req_op_mod_i[i];
      lane[i].ctrl.rnd_mode     = req_rnd_mode_i[i];
      lane[i].ctrl.src_fmt      = req_src_fmt_i[i];
      lane[i].ctrl.dst_fmt      = req_dst_fmt_i[i];
      lane[i].ctrl.int_fmt      = req_int_fmt_i[i];
      lane[i].ctrl.vectorial_op = req_vectorial_op_i[i];
      lane[i].tag               = req_tag_i[i];
      elig[i] = rst_ni & req_valid_i[i]
              & (cnt_q[i] < CntW'(MaxOutstanding));
    end
  end

  fpnew_rr_lock_arbiter #(
    .N (NumReq)
  ) u_arb (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .flush (flush_i),
    .elig  (elig),
    .ready (fpu_in_ready_i),
    .valid (arb_valid),
    .idx   (gnt_idx),
    .gnt   (gnt)
  );

  assign sel                = lane[gnt_idx];
  assign fpu_in_valid_o     = arb_valid;
  assign req_ready_o        = gnt & {NumReq{fpu_in_ready_i}};
  assign fpu_operands_o     = sel.operands;
  assign fpu_op_o           = sel.ctrl.op;
  assign fpu_op_mod_o       = sel.ctrl.op_mod;
  assign fpu_rnd_mode_o     = sel.ctrl.rnd_mode;
  assign fpu_src_fmt_o      = sel.ctrl.src_fmt;
  assign fpu_dst_fmt_o      = sel.ctrl.dst_fmt;
  assign fpu_int_fmt_o      = sel.ctrl.int_fmt;
  assign fpu_vectorial_op_o = sel.ctrl.vectorial_op;
  assign fpu_tag_o = TagW'(req_arb_tag(NumReq, UserTagWidth,
                                       32'(gnt_idx),
                                       req_arb_tag_t'(sel.tag)));

  // Out-of-range indices are sunk so a bad tag cannot wedge the FPU.
  assign rsp_idx         = fpu_tag_i[TagW-1 -: IdxW];
  assign idx_ok          = 32'(rsp_idx) < NumReq;
  assign rsp_valid_o     = {NumReq{rst_ni & fpu_out_valid_i & idx_ok}}
                         & (NumReq'(1) << rsp_idx);
  assign fpu_out_ready_o = rst_ni & (~idx_ok | rsp_ready_i[rsp_idx]);
  assign rsp_hs          = rsp_valid_o & rsp_ready_i;
  assign rsp_result_o    = fpu_result_i;
  assign rsp_status_o    = fpu_status_i;
  assign rsp_tag_o       = fpu_tag_i[UserTagWidth-1:0];
  assign busy_o          = rst_ni & ((|cnt_q) | arb_valid);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (flush_i) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NumReq; i++) begin
        if (req_ready_o[i] && !rsp_hs[i]
            && cnt_q[i] != CntW'(MaxOutstanding)) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end else if (rsp_hs[i] && !req_ready_o[i]
                     && cnt_q[i] != '0) begin
          cnt_q[i] <= cnt_q[i] - 1'b1;
        end
      end
    end
  end

`ifndef SYNTHESIS
  a_idx_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    fpu_out_valid_i |-> idx_ok);

  for (genvar i = 0; i < NumReq; i++) begin : g_chk
    a_no_underflow: assert property (
      @(posedge clk_i) disable iff (!rst_ni || flush_i)
      rsp_hs[i] |-> cnt_q[i] != '0);
  end
`endif

endmodule

// File: tb/tb_fpnew_req_arbiter.sv
// Randomized bench for fpnew_req_arbiter against a behavioural model
// of round-robin issue, stall lock, credits and result routing.
module tb_fpnew_req_arbiter;
  import fpnew_pkg::*;

  localparam int NR = 4;
  localparam int W  = 32;
  localparam int NO = 3;
  localparam int UT = 4;
  localparam int MO = 4;
  localparam int TW = 6;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic flush_i = 1'b0;
  logic [NR-1:0] req_valid_i = '0;
  logic [NR-1:0] req_ready_o;
  logic [NR-1:0][NO-1:0][W-1:0] req_operands_i;
  operation_e [NR-1:0] req_op_i;
  logic [NR-1:0] req_op_mod_i;
  roundmode_e [NR-1:0] req_rnd_mode_i;
  fp_format_e [NR-1:0] req_src_fmt_i;
  fp_format_e [NR-1:0] req_dst_fmt_i;
  int_format_e [NR-1:0] req_int_fmt_i;
  logic [NR-1:0] req_vectorial_op_i;
  logic [NR-1:0][UT-1:0] req_tag_i;
  logic fpu_in_valid_o;
  logic fpu_in_ready_i = 1'b0;
  logic [NO-1:0][W-1:0] fpu_operands_o;
  operation_e fpu_op_o;
  logic fpu_op_mod_o;
  roundmode_e fpu_rnd_mode_o;
  fp_format_e fpu_src_fmt_o;
  fp_format_e fpu_dst_fmt_o;
  int_format_e fpu_int_fmt_o;
  logic fpu_vectorial_op_o;
  logic [TW-1:0] fpu_tag_o;
  logic fpu_out_valid_i = 1'b0;
  logic fpu_out_ready_o;
  logic [W-1:0] fpu_result_i = '0;
  status_t fpu_status_i = '0;
  logic [TW-1:0] fpu_tag_i = '0;
  logic [NR-1:0] rsp_valid_o;
  logic [NR-1:0] rsp_ready_i = '0;
  logic [W-1:0] rsp_result_o;
  status_t rsp_status_o;
  logic [UT-1:0] rsp_tag_o;
  logic busy_o;

  int checks = 0;
  int errors = 0;

  int m_cnt[NR];
  int m_ptr;
  bit m_lock;
  int m_lidx;
  bit hold[NR];

  always #5 clk = ~clk;

  fpnew_req_arbiter #(
    .NumReq(NR), .Width(W), .NumOperands(NO),
    .UserTagWidth(UT), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_operands_i(req_operands_i), .req_op_i(req_op_i),
    .req_op_mod_i(req_op_mod_i), .req_rnd_mode_i(req_rnd_mode_i),
    .req_src_fmt_i(req_src_fmt_i), .req_dst_fmt_i(req_dst_fmt_i),
    .req_int_fmt_i(req_int_fmt_i),
    .req_vectorial_op_i(req_vectorial_op_i), .req_tag_i(req_tag_i),
    .fpu_in_valid_o(fpu_in_valid_o), .fpu_in_ready_i(fpu_in_ready_i),
    .fpu_operands_o(fpu_operands_o), .fpu_op_o(fpu_op_o),
    .fpu_op_mod_o(fpu_op_mod_o), .fpu_rnd_mode_o(fpu_rnd_mode_o),
    .fpu_src_fmt_o(fpu_src_fmt_o), .fpu_dst_fmt_o(fpu_dst_fmt_o),
    .fpu_int_fmt_o(fpu_int_fmt_o),
    .fpu_vectorial_op_o(fpu_vectorial_op_o), .fpu_tag_o(fpu_tag_o),
    .fpu_out_valid_i(fpu_out_valid_i), .fpu_out_ready_o(fpu_out_ready_o),
    .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i),
    .fpu_tag_i(fpu_tag_i), .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i), .rsp_result_o(rsp_result_o),
    .rsp_status_o(rsp_status_o), .rsp_tag_o(rsp_tag_o), .busy_o(busy_o)
  );

  task automatic rand_lane(input int i);
    req_operands_i[i] = {$urandom, $urandom, $urandom};
    req_op_i[i] = operation_e'(4'($urandom_range(0, 14)));
    req_op_mod_i[i] = 1'($urandom);
    req_rnd_mode_i[i] = roundmode_e'(3'($urandom_range(0, 4)));
    req_src_fmt_i[i] = fp_format_e'(3'($urandom_range(0, 4)));
    req_dst_fmt_i[i] = fp_format_e'(3'($urandom_range(0, 4)));
    req_int_fmt_i[i] = int_format_e'(2'($urandom));
    req_vectorial_op_i[i] = 1'($urandom);
    req_tag_i[i] = 4'($urandom);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_cnt[i] = 0;
      hold[i] = 0;
    end
    m_ptr = 0;
    m_lock = 0;
    m_lidx = 0;
  endtask

  function automatic bit m_elig(input int j);
    return req_valid_i[j] && m_cnt[j] < MO;
  endfunction

  // Locked requester first, otherwise first eligible from the pointer.
  function automatic int m_grant();
    if (m_lock && m_elig(m_lidx)) return m_lidx;
    for (int k = 0; k < NR; k++)
      if (m_elig((m_ptr + k) % NR)) return (m_ptr + k) % NR;
    return -1;
  endfunction

  task automatic model_step();
    int g;
    int r;
    bit ihs;
    bit rhs;
    g = m_grant();
    ihs = (g >= 0) && fpu_in_ready_i;
    r = int'(fpu_tag_i[TW-1:UT]);
    rhs = fpu_out_valid_i && rsp_ready_i[r];
    for (int i = 0; i < NR; i++)
      hold[i] = req_valid_i[i] && !(ihs && g == i);
    if (!rst_ni) begin
      model_reset();
    end else if (flush_i) begin
      for (int i = 0; i < NR; i++) m_cnt[i] = 0;
      m_lock = 0;
    end else begin
      if (ihs) m_cnt[g]++;
      if (rhs && m_cnt[r] > 0) m_cnt[r]--;
      m_lock = (g >= 0) && !fpu_in_ready_i;
      if (m_lock) m_lidx = g;
      if (ihs) m_ptr = (g + 1) % NR;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drain();
    req_valid_i = '0;
    rsp_ready_i = '1;
    for (int i = 0; i < NR; i++) begin
      for (int n = 0; n < 8 && m_cnt[i] > 0; n++) begin
        fpu_out_valid_i = 1'b1;
        fpu_tag_i = {2'(i), 4'h0};
        advance();
      end
    end
    fpu_out_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    req_valid_i = '1;
    fpu_in_ready_i = 1'b1;
    fpu_out_valid_i = 1'b1;
    rsp_ready_i = '1;
    #12;
    checks++; if (fpu_in_valid_o !== 1'b0) begin errors++;
      $display("FAIL reset_in_valid got %b exp 0", fpu_in_valid_o); end
    checks++; if (req_ready_o !== 4'b0) begin errors++;
      $display("FAIL reset_req_ready got %b exp 0000", req_ready_o); end
    checks++; if (rsp_valid_o !== 4'b0) begin errors++;
      $display("FAIL reset_rsp_valid got %b exp 0000", rsp_valid_o); end
    checks++; if (fpu_out_ready_o !== 1'b0) begin errors++;
      $display("FAIL reset_out_ready got %b exp 0", fpu_out_ready_o); end
    checks++; if (busy_o !== 1'b0) begin errors++;
      $display("FAIL reset_busy got %b exp 0", busy_o); end
    req_valid_i = '0;
    fpu_in_ready_i = 1'b0;
    fpu_out_valid_i = 1'b0;
    rsp_ready_i = '0;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    model_reset();
  endtask

  task automatic test_fairness();
    int issued;
    int cyc;
    int eg;
    int cnt_by[NR];
    int q_idx[$];
    int q_cyc[$];
    bit ret;
    issued = 0;
    cyc = 0;
    for (int i = 0; i < NR; i++) cnt_by[i] = 0;
    req_valid_i = '1;
    fpu_in_ready_i = 1'b1;
    rsp_ready_i = '1;
    while (issued < 100 && cyc < 400) begin
      ret = q_idx.size() > 0 && q_cyc[0] <= cyc - 2;
      fpu_out_valid_i = ret;
      fpu_result_i = $urandom;
      if (ret) fpu_tag_i = {2'(q_idx[0]), 4'($urandom)};
      eg = issued % NR;
      @(negedge clk);
      checks++; if (req_ready_o !== 4'(1 << eg)) begin errors++;
        $display("FAIL fair_grant got %b exp %b", req_ready_o, 4'(1 << eg)); end
      checks++; if (fpu_tag_o !== {2'(eg), req_tag_i[eg]}) begin errors++;
        $display("FAIL fair_tag got %h exp %h", fpu_tag_o, {2'(eg), req_tag_i[eg]}); end
      checks++; if (fpu_operands_o !== req_operands_i[eg]) begin errors++;
        $display("FAIL fair_operands got %h exp %h", fpu_operands_o, req_operands_i[eg]); end
      if (ret) begin
        checks++; if (rsp_valid_o !== 4'(1 << q_idx[0])) begin errors++;
          $display("FAIL fair_rsp_valid got %b exp %b", rsp_valid_o, 4'(1 << q_idx[0])); end
      end
      advance();
      cnt_by[eg]++;
      issued++;
      q_idx.push_back(eg);
      q_cyc.push_back(cyc);
      if (ret) begin
        void'(q_idx.pop_front());
        void'(q_cyc.pop_front());
      end
      rand_lane(eg);
      cyc++;
    end
    checks++; if (issued != 100) begin errors++;
      $display("FAIL fair_timeout got %0d exp 100", issued); end
    for (int i = 0; i < NR; i++) begin
      checks++; if (cnt_by[i] != 25) begin errors++;
        $display("FAIL fair_share%0d got %0d exp 25", i, cnt_by[i]); end
    end
    fpu_in_ready_i = 1'b0;
    drain();
  endtask

  task automatic test_stall_lock();
    req_valid_i = 4'b0001;
    fpu_in_ready_i = 1'b1;
    @(negedge clk);
    checks++; if (req_ready_o !== 4'b0001) begin errors++;
      $display("FAIL stall_setup got %b exp 0001", req_ready_o); end
    advance();
    rand_lane(0);
    fpu_in_ready_i = 1'b0;
    drain();
    req_valid_i = 4'b0110;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (req_ready_o !== 4'b0000 || fpu_in_valid_o !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold got %b/%b exp 0000/1", req_ready_o, fpu_in_valid_o); end
      checks++; if (fpu_tag_o !== {2'd1, req_tag_i[1]}
                    || fpu_operands_o !== req_operands_i[1]) begin errors++;
        $display("FAIL stall_data got %h exp %h", fpu_tag_o, {2'd1, req_tag_i[1]}); end
      advance();
    end
    fpu_in_ready_i = 1'b1;
    @(negedge clk);
    checks++; if (req_ready_o !== 4'b0010) begin errors++;
      $display("FAIL stall_release got %b exp 0010", req_ready_o); end
    advance();
    rand_lane(1);
    @(negedge clk);
    checks++; if (req_ready_o !== 4'b0100) begin errors++;
      $display("FAIL stall_ptr got %b exp 0100", req_ready_o); end
    advance();
    rand_lane(2);
    req_valid_i = 4'b0100;
    fpu_in_ready_i = 1'b0;
    advance();
    req_valid_i = 4'b0110;
    @(negedge clk);
    checks++; if (fpu_tag_o[TW-1:UT] !== 2'd2) begin errors++;
      $display("FAIL lock_over_ptr got %0d exp 2", fpu_tag_o[TW-1:UT]); end
    advance();
    fpu_in_ready_i = 1'b1;
    @(negedge clk);
    checks++; if (req_ready_o !== 4'b0100) begin errors++;
      $display("FAIL lock_release got %b exp 0100", req_ready_o); end
    advance();
    rand_lane(2);
    req_valid_i = 4'b0010;
    @(negedge clk);
    checks++; if (req_ready_o !== 4'b0010) begin errors++;
      $display("FAIL lock_after got %b exp 0010", req_ready_o); end
    advance();
    rand_lane(1);
    fpu_in_ready_i = 1'b0;
    drain();
  endtask

  task automatic test_credit_block();
    req_valid_i = 4'b0001;
    fpu_in_ready_i = 1'b1;
    for (int k = 0; k < MO; k++) begin
      @(negedge clk);
      checks++; if (req_ready_o !== 4'b0001) begin errors++;
        $display("FAIL credit_issue%0d got %b exp 0001", k, req_ready_o); end
      advance();
      rand_lane(0);
    end
    req_valid_i = 4'b1001;
    @(negedge clk);
    checks++; if (req_ready_o !== 4'b1000) begin errors++;
      $display("FAIL credit_block got %b exp 1000", req_ready_o); end
    advance();
    rand_lane(3);
    req_valid_i = 4'b0001;
    fpu_out_valid_i = 1'b1;
    fpu_tag_i = {2'd0, 4'h3};
    rsp_ready_i = '1;
    @(negedge clk);
    checks++; if (fpu_in_valid_o !== 1'b0 || busy_o !== 1'b1) begin errors++;
      $display("FAIL credit_full got %b/%b exp 0/1", fpu_in_valid_o, busy_o); end
    checks++; if (rsp_valid_o !== 4'b0001) begin errors++;
      $display("FAIL credit_rsp got %b exp 0001", rsp_valid_o); end
    advance();
    fpu_out_valid_i = 1'b0;
    @(negedge clk);
    checks++; if (req_ready_o !== 4'b0001) begin errors++;
      $display("FAIL credit_reissue got %b exp 0001", req_ready_o); end
    advance();
    rand_lane(0);
    fpu_in_ready_i = 1'b0;
    drain();
  endtask

  task automatic test_routing();
    req_valid_i = 4'b0100;
    fpu_in_ready_i = 1'b1;
    advance();
    rand_lane(2);
    req_valid_i = '0;
    fpu_in_ready_i = 1'b0;
    fpu_out_valid_i = 1'b1;
    fpu_tag_i = {2'd2, 4'hA};
    fpu_result_i = $urandom;
    rsp_ready_i = 4'b1011;
    @(negedge clk);
    checks++; if (rsp_valid_o !== 4'b0100 || rsp_tag_o !== 4'hA) begin errors++;
      $display("FAIL route_valid got %b/%h exp 0100/a", rsp_valid_o, rsp_tag_o); end
    checks++; if (fpu_out_ready_o !== 1'b0 || rsp_result_o !== fpu_result_i) begin
      errors++;
      $display("FAIL route_bp got %b exp 0", fpu_out_ready_o); end
    advance();
    checks++; if (dut.cnt_q[2] !== 3'(m_cnt[2]) || m_cnt[2] != 1) begin errors++;
      $display("FAIL route_hold got %0d exp 1", dut.cnt_q[2]); end
    rsp_ready_i = '1;
    @(negedge clk);
    checks++; if (fpu_out_ready_o !== 1'b1) begin errors++;
      $display("FAIL route_ready got %b exp 1", fpu_out_ready_o); end
    advance();
    fpu_out_valid_i = 1'b0;
    checks++; if (dut.cnt_q[2] !== 3'd0) begin errors++;
      $display("FAIL route_dec got %0d exp 0", dut.cnt_q[2]); end
  endtask

  task automatic test_simultaneous();
    req_valid_i = 4'b1000;
    fpu_in_ready_i = 1'b1;
    rsp_ready_i = '1;
    repeat (2) begin
      advance();
      rand_lane(3);
    end
    fpu_out_valid_i = 1'b1;
    fpu_tag_i = {2'd3, 4'h5};
    @(negedge clk);
    checks++; if (req_ready_o !== 4'b1000 || rsp_valid_o !== 4'b1000) begin
      errors++;
      $display("FAIL simul_hs got %b/%b exp 1000/1000", req_ready_o, rsp_valid_o); end
    advance();
    rand_lane(3);
    checks++; if (dut.cnt_q[3] !== 3'd2) begin errors++;
      $display("FAIL simul_cnt got %0d exp 2", dut.cnt_q[3]); end
    fpu_out_valid_i = 1'b0;
    fpu_in_ready_i = 1'b0;
    drain();
  endtask

  task automatic test_flush_reset();
    int tgt[NR] = '{2, 0, 3, 1};
    fpu_in_ready_i = 1'b1;
    for (int i = 0; i < NR; i++) begin
      for (int k = 0; k < tgt[i]; k++) begin
        req_valid_i = 4'(1 << i);
        advance();
        rand_lane(i);
      end
    end
    req_valid_i = 4'b0001;
    fpu_in_ready_i = 1'b0;
    advance();
    checks++; if (dut.u_arb.lock_q !== 1'b1) begin errors++;
      $display("FAIL flush_lock_set got %b exp 1", dut.u_arb.lock_q); end
    flush_i = 1'b1;
    req_valid_i = '0;
    advance();
    flush_i = 1'b0;
    @(negedge clk);
    checks++; if (busy_o !== 1'b0 || dut.u_arb.lock_q !== 1'b0) begin errors++;
      $display("FAIL flush_state got %b/%b exp 0/0", busy_o, dut.u_arb.lock_q); end
    for (int i = 0; i < NR; i++) begin
      checks++; if (dut.cnt_q[i] !== 3'(m_cnt[i]) || m_cnt[i] != 0) begin errors++;
        $display("FAIL flush_cnt%0d got %0d exp 0", i, dut.cnt_q[i]); end
    end
    advance();
    req_valid_i = 4'b0100;
    fpu_in_ready_i = 1'b1;
    advance();
    rand_lane(2);
    req_valid_i = 4'b0010;
    fpu_in_ready_i = 1'b0;
    advance();
    fpu_out_valid_i = 1'b1;
    fpu_tag_i = {2'd2, 4'h1};
    rsp_ready_i = '1;
    #2;
    rst_ni = 1'b0;
    #1;
    checks++; if (fpu_in_valid_o !== 1'b0 || req_ready_o !== 4'b0) begin errors++;
      $display("FAIL rst_mid_issue got %b/%b exp 0/0000", fpu_in_valid_o, req_ready_o); end
    checks++; if (rsp_valid_o !== 4'b0 || fpu_out_ready_o !== 1'b0
                  || busy_o !== 1'b0) begin errors++;
      $display("FAIL rst_mid_rsp got %b/%b/%b exp 0000/0/0", rsp_valid_o,
               fpu_out_ready_o, busy_o); end
    checks++; if (dut.cnt_q[2] !== 3'd0 || dut.u_arb.lock_q !== 1'b0) begin errors++;
      $display("FAIL rst_mid_state got %0d/%b exp 0/0", dut.cnt_q[2], dut.u_arb.lock_q); end
    req_valid_i = '0;
    fpu_out_valid_i = 1'b0;
    rsp_ready_i = '0;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    int eg;
    int j;
    logic [NR-1:0] e_rdy;
    logic [NR-1:0] e_rsp;
    logic e_ordy;
    logic e_busy;
    for (int i = 0; i < NR; i++) rand_lane(i);
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!hold[i]) begin
          req_valid_i[i] = $urandom_range(0, 2) != 0;
          rand_lane(i);
        end
      end
      fpu_in_ready_i = $urandom_range(0, 3) != 0;
      j = $urandom_range(0, NR - 1);
      fpu_out_valid_i = m_cnt[j] > 0 && $urandom_range(0, 1) == 1;
      fpu_tag_i = {2'(j), 4'($urandom)};
      fpu_result_i = $urandom;
      fpu_status_i = status_t'(5'($urandom));
      rsp_ready_i = 4'($urandom);
      eg = m_grant();
      e_rdy = (eg >= 0 && fpu_in_ready_i) ? 4'(1 << eg) : 4'b0;
      e_rsp = fpu_out_valid_i ? 4'(1 << j) : 4'b0;
      e_ordy = rsp_ready_i[j];
      e_busy = (eg >= 0);
      for (int i = 0; i < NR; i++) if (m_cnt[i] > 0) e_busy = 1'b1;
      @(negedge clk);
      checks++; if (fpu_in_valid_o !== (eg >= 0) || req_ready_o !== e_rdy) begin
        errors++;
        $display("FAIL rnd_issue c%0d got %b/%b exp %b/%b", c, fpu_in_valid_o,
                 req_ready_o, eg >= 0, e_rdy); end
      if (eg >= 0) begin
        checks++; if (fpu_tag_o !== {2'(eg), req_tag_i[eg]}
                      || fpu_operands_o !== req_operands_i[eg]
                      || fpu_op_o !== req_op_i[eg]
                      || fpu_rnd_mode_o !== req_rnd_mode_i[eg]) begin errors++;
          $display("FAIL rnd_mux c%0d got %h exp %h", c, fpu_tag_o,
                   {2'(eg), req_tag_i[eg]}); end
      end
      checks++; if (rsp_valid_o !== e_rsp || fpu_out_ready_o !== e_ordy) begin
        errors++;
        $display("FAIL rnd_rsp c%0d got %b/%b exp %b/%b", c, rsp_valid_o,
                 fpu_out_ready_o, e_rsp, e_ordy); end
      checks++; if (rsp_tag_o !== fpu_tag_i[UT-1:0] || rsp_result_o !== fpu_result_i
                    || rsp_status_o !== fpu_status_i) begin errors++;
        $display("FAIL rnd_rsp_data c%0d got %h exp %h", c, rsp_result_o, fpu_result_i); end
      checks++; if (busy_o !== e_busy) begin errors++;
        $display("FAIL rnd_busy c%0d got %b exp %b", c, busy_o, e_busy); end
      advance();
    end
    fpu_in_ready_i = 1'b0;
    drain();
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < NR; i++) rand_lane(i);
    test_reset();
    test_fairness();
    test_stall_lock();
    test_credit_block();
    test_routing();
    test_simultaneous();
    test_flush_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpnew_req_arbiter.md
Name: fpnew_req_arbiter

Overview:
- Shares one FPU instance (top-level issue/result handshake, opgroup blocks behind it) among NumReq independent requesters, e.g. cores or lanes.
- Round-robin arbitration on issue, with a request lock while the FPU stalls.
- Per-requester outstanding-operation credits.
- Each result is routed back to its originator using a requester index carried in the FPU tag.

Parameters:
NumReq, 4, number of requesters (>=2)
Width, 32, FPU operand/result width
NumOperands, 3, operands per request
UserTagWidth, 4, requester-private tag bits carried through the FPU
MaxOutstanding, 4, issued-but-unreturned ops allowed per requester (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  drop all in-flight bookkeeping; same cycle as FPU flush
req_valid_i  in  NumReq  issue request per requester
req_ready_o  out  NumReq  issue accepted
req_operands_i  in  NumReq x NumOperands x Width  operands
req_op_i / req_op_mod_i / req_rnd_mode_i  in  NumReq x (operation_e / 1 / roundmode_e)  operation fields
req_src_fmt_i / req_dst_fmt_i / req_int_fmt_i / req_vectorial_op_i  in  NumReq x (fp_format_e / fp_format_e / int_format_e / 1)  format fields
req_tag_i  in  NumReq x UserTagWidth  requester tag
fpu_in_valid_o  out  1  to FPU
fpu_in_ready_i  in  1  from FPU
fpu_operands_o, fpu_op_o, fpu_op_mod_o, fpu_rnd_mode_o, fpu_src_fmt_o, fpu_dst_fmt_o, fpu_int_fmt_o, fpu_vectorial_op_o  out  as above, one lane  selected request
fpu_tag_o  out  IdxW+UserTagWidth  {requester index, user tag}; IdxW = clog2(NumReq)
fpu_out_valid_i  in  1  FPU result valid
fpu_out_ready_o  out  1  to FPU
fpu_result_i  in  Width  result
fpu_status_i  in  status_t  flags
fpu_tag_i  in  IdxW+UserTagWidth  returned tag
rsp_valid_o  out  NumReq  one-hot response valid
rsp_ready_i  in  NumReq  per-requester response ready
rsp_result_o  out  Width  shared response bus
rsp_status_o  out  status_t  shared
rsp_tag_o  out  UserTagWidth  user tag bits of fpu_tag_i
busy_o  out  1  any outstanding op or FPU request pending

Behaviour:
- Reset values: rr pointer = 0, lock = 0, all credit counters = 0. Outputs at reset: fpu_in_valid_o = 0, req_ready_o = 0, rsp_valid_o = 0, fpu_out_ready_o = 0, busy_o = 0.
- Eligibility: requester i is eligible when req_valid_i[i] and cnt[i] < MaxOutstanding.
- Arbitration, zero latency, combinational:
  - Grant the first eligible index at or after the rr pointer, wrapping.
  - fpu_in_valid_o = any eligible; the granted request's fields drive the fpu_* outputs.
  - req_ready_o[g] = fpu_in_ready_i for the granted g only.
- Lock (valid/ready stability):
  - If fpu_in_valid_o and !fpu_in_ready_i, register lock = 1 and the locked index.
  - Next cycle the same index is granted regardless of the pointer.
  - Lock clears on handshake. Requesters must hold valid and data until ready.
- Pointer: on an issue handshake, rr pointer <= g+1, wrapping NumReq-1 -> 0.
- Response routing, combinational:
  - idx = fpu_tag_i[MSBs].
  - rsp_valid_o = fpu_out_valid_i << idx.
  - fpu_out_ready_o = rsp_ready_i[idx].
  - An idx >= NumReq (non-power-of-two NumReq) is an assertion error; in that case fpu_out_ready_o = 1, the result is dropped, and no counter changes.
- Credit counter cnt[i], width clog2(MaxOutstanding+1):
  - +1 on issue handshake for i.
  - -1 on response handshake for i.
  - Both in the same cycle: unchanged.
  - Never exceeds MaxOutstanding; never underflows (response at cnt = 0 is an assertion error and is clamped).
- Flush: all counters <= 0, lock <= 0, pointer unchanged. fpu_in_valid_o is still driven combinationally in the flush cycle, but handshakes in that cycle do not update counters.
- busy_o = (|cnt) | fpu_in_valid_o.
- Reset mid-operation: the asynchronous reset immediately forces the reset values. The FPU must be reset by the same rst_ni.

Decomposition:
- Shared package fpnew_pkg gains:
  - the req_arb_tag_t packing helper: function building {idx, user tag} for given NumReq and UserTagWidth;
  - the request bundle struct (operands + op fields) so lanes are muxed as one vector.
- One sub-module: fpnew_rr_lock_arbiter. It holds the pointer, lock, eligibility mask in and grant index out, and is reusable for the opgroup output side.

Test Plan:
- Fairness: all 4 requesters valid continuously, FPU always ready, MaxOutstanding = 4, results return after 2 cycles. Required grant order 0,1,2,3,0,... and each requester gets exactly 25 of 100 issues.
- Stall lock: req1 and req2 valid, pointer at 1, fpu_in_ready_i = 0 for 3 cycles. The grant stays 1 with identical fpu_* outputs for all 3 cycles; when ready goes high, req_ready_o = 0010 and the pointer moves to 2.
- Credit block: req0 issues 4 ops, no results returned. req_ready_o[0] stays 0 and req3 is granted. The first result with tag idx 0 returns, and req0 issues again the following cycle.
- Routing/backpressure: result with fpu_tag_i = {2, 4'hA} and rsp_ready_i[2] = 0. Required: rsp_valid_o = 0100, rsp_tag_o = 4'hA, fpu_out_ready_o = 0, cnt[2] held. When rsp_ready_i[2] = 1, the handshake completes and cnt[2] decrements.
- Simultaneous issue and return for requester 3 at cnt = 2: cnt stays 2.
- Flush with cnt = {1,3,0,2} and lock set: next cycle all cnt = 0, lock clear, busy_o = 0 if no requester is valid. Assert rst_ni low mid-stall: outputs are at reset values in the same cycle.
